// File: rtl/bus_mem_responder.sv
// -----------------------------------------------------------------------------
// bus_mem_responder
//
// Data-side memory responder for the core's load/store port. Holds a
// byte-maskable word RAM, posts writes in the acceptance cycle and answers
// reads through a small FSM (IDLE / WAIT / DONE) that inserts WAIT_STATES
// cycles before presenting the read word together with bus_done.
//
// Parameters:
//   MEM_SIZE_W  - RAM depth in 32-bit words (power of two, >= 2)
//   WAIT_STATES - extra cycles between read acceptance and data valid (0..15)
//   BASE_ADDR   - byte address of word 0 (4-byte aligned)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active high
//   bus_addr   in   byte address, bits [1:0] ignored
//   bus_wdata  in   lane-aligned write data
//   bus_wmask  in   byte-lane write enables
//   bus_wen    in   write request
//   bus_ren    in   read request
//   bus_rdata  out  read word, valid while bus_done is high in DONE
//   bus_done   out  responder ready / read data valid
//   bus_err    out  sticky out-of-range flag
//
// Optional feature macro: BUS_RESP_RANGE_CHECK_EN
//   defined     - out-of-range writes are dropped, out-of-range reads return
//                 32'hDEAD_BEEF, and any out-of-range request sets bus_err.
//   not defined - the word index wraps modulo MEM_SIZE_W, bus_err is 0.
// -----------------------------------------------------------------------------
module bus_mem_responder #(
   parameter int unsigned MEM_SIZE_W  = 1024,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   input  logic [3:0]  bus_wmask,
   input  logic        bus_wen,
   input  logic        bus_ren,
   output logic [31:0] bus_rdata,
   output logic        bus_done,
   output logic        bus_err
);

   localparam int unsigned IDX_W     = (MEM_SIZE_W > 1) ? $clog2(MEM_SIZE_W) : 1;
   localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE_W);
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);
   localparam logic [31:0] OOR_DATA  = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic             done_r;
   logic [31:0]      rdata_r;
   logic [3:0]       cnt_r;
   logic [IDX_W-1:0] rd_idx_r;
   logic             rd_oor_r;
   logic [31:0]      mem_r [MEM_SIZE_W];

   logic [31:0]      offset_s;
   logic [IDX_W-1:0] req_idx_s;
   logic             req_oor_s;
   logic             accept_s;
   logic             wr_acc_s;
   logic             rd_acc_s;
   logic [IDX_W-1:0] rd_addr_s;
   logic             rd_sel_oor_s;

   assign offset_s  = bus_addr - BASE_ADDR;
   assign req_idx_s = offset_s[IDX_W+1:2];

`ifdef BUS_RESP_RANGE_CHECK_EN
   logic err_r;
   logic unused_s;

   // Below the base, or a word index past the end of the RAM
   assign req_oor_s = (bus_addr < BASE_ADDR) || ({2'b00, offset_s[31:2]} >= MEM_WORDS);
   assign unused_s  = ^offset_s[1:0];

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if ((wr_acc_s || rd_acc_s) && req_oor_s) begin
         err_r <= 1'b1;
      end
   end

   assign bus_err = err_r;
`else
   logic unused_s;

   // No range decode: upper offset bits are dropped so the index wraps
   assign req_oor_s = 1'b0;
   assign unused_s  = ^{offset_s[31:IDX_W+2], offset_s[1:0], MEM_WORDS};
   assign bus_err   = 1'b0;
`endif

   // Requests are only taken when not counting wait states; write wins a tie
   assign accept_s = (state_r != ST_WAIT);
   assign wr_acc_s = accept_s && bus_wen;
   assign rd_acc_s = accept_s && bus_ren && !bus_wen;

   // Single RAM read port: latched index while waiting, live request otherwise
   always_comb begin
      rd_addr_s    = req_idx_s;
      rd_sel_oor_s = req_oor_s;
      if (state_r == ST_WAIT) begin
         rd_addr_s    = rd_idx_r;
         rd_sel_oor_s = rd_oor_r;
      end else begin
         rd_addr_s    = req_idx_s;
         rd_sel_oor_s = req_oor_s;
      end
   end

   // Byte-lane write port; committed at the acceptance edge
   always_ff @(posedge clk) begin
      if (wr_acc_s && !req_oor_s) begin
         for (int i = 0; i < 4; i++) begin
            if (bus_wmask[i]) begin
               mem_r[req_idx_s][8*i +: 8] <= bus_wdata[8*i +: 8];
            end
         end
      end
   end

   // Response FSM with registered done flag and read-data register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         done_r   <= 1'b1;
         rdata_r  <= 32'h0000_0000;
         cnt_r    <= 4'd0;
         rd_idx_r <= '0;
         rd_oor_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (wr_acc_s) begin
                  // Posted write: no response phase, rdata left untouched
                  state_r <= ST_IDLE;
                  done_r  <= 1'b1;
               end else if (rd_acc_s) begin
                  rd_idx_r <= req_idx_s;
                  rd_oor_r <= req_oor_s;
                  cnt_r    <= WAIT_LOAD;
                  if (WAIT_STATES == 0) begin
                     // Zero wait: the acceptance edge is also the RAM read edge
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                     rdata_r <= rd_sel_oor_s ? OOR_DATA : mem_r[rd_addr_s];
                  end else begin
                     state_r <= ST_WAIT;
                     done_r  <= 1'b0;
                  end
               end else begin
                  state_r <= ST_IDLE;
                  done_r  <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (cnt_r == 4'd1) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
                  cnt_r   <= 4'd0;
                  rdata_r <= rd_sel_oor_s ? OOR_DATA : mem_r[rd_addr_s];
               end else begin
                  state_r <= ST_WAIT;
                  done_r  <= 1'b0;
                  cnt_r   <= cnt_r - 4'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b1;
               cnt_r   <= 4'd0;
            end
         endcase
      end
   end

   assign bus_rdata = rdata_r;
   assign bus_done  = done_r;

endmodule

// File: doc/bus_mem_responder.md
# bus_mem_responder

Data-bus responder for the pipelined core's load/store port: accepts the core's single-cycle `bus_ren`/`bus_wen` requests, holds a byte-maskable word RAM, and returns read data with `bus_done` after a configurable number of wait states. It sits on the data side of the modified-Harvard system, opposite the core's bus initiator. Writes are posted; reads are tracked by a small FSM so the core's WB stall logic sees correct `bus_done` timing.

## Interface
- `MEM_SIZE_W`, 1024: RAM depth in 32-bit words; power of two.
- `WAIT_STATES`, 0: extra cycles between read acceptance and data valid; range 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; 4-byte aligned.
- `rst`  in  1  asynchronous reset, active-high.
- `clk`  in  1  clock; all state changes on rising edge.
- `bus_addr`  in  32  byte address; bits [1:0] ignored.
- `bus_wdata`  in  32  lane-aligned write data.
- `bus_wmask`  in  4  byte-lane write enables; bit i writes `bus_wdata[8i+7:8i]`.
- `bus_wen`  in  1  write request.
- `bus_ren`  in  1  read request.
- `bus_rdata`  out  32  full read word; the initiator extracts bytes/halves.
- `bus_done`  out  1  high when the responder can accept a request; in DONE it also marks `bus_rdata` valid.
- `bus_err`  out  1  sticky out-of-range flag (see Configuration).

## Operation
- Word index = `(bus_addr - BASE_ADDR) >> 2`. The address is in range when `bus_addr >= BASE_ADDR` and the index is `< MEM_SIZE_W`.
- FSM states:
  - IDLE: `bus_done`=1; accepts requests.
  - WAIT: `bus_done`=0; counts down and ignores requests.
  - DONE: `bus_done`=1; `bus_rdata` valid; accepts requests.
- Acceptance happens only in IDLE or DONE. A request presented in WAIT is neither accepted nor dropped. The initiator holds it, and it is accepted once the FSM reaches DONE.
- Accepted write (`bus_wen`=1):
  - Masked bytes are committed at the acceptance edge.
  - Next state is IDLE; no response phase.
  - `wmask`=0 makes it a no-op.
- Accepted read (`bus_ren`=1, `bus_wen`=0):
  - Word index is latched and the counter loads `WAIT_STATES`.
  - Next state is WAIT if `WAIT_STATES`>0, else DONE.
- WAIT: decrement each cycle. When the counter reaches 1, the next state is DONE and `bus_rdata` loads the RAM word.
- DONE with no new request: next state IDLE. `bus_rdata` holds its value until the next read completes.
- `bus_ren` and `bus_wen` both high: treated as a write only; no read response.
- Read-after-write: a read accepted the cycle after a write to the same word returns the new data.
- A write accepted in DONE does not alter the `bus_rdata` already presented.
- Reset values (async):
  - State: IDLE.
  - `bus_done`: 1.
  - `bus_rdata`: 0.
  - Counter: 0.
  - `bus_err`: 0.
  - RAM contents are not reset.
- Reset asserted mid-read (WAIT or DONE) abandons the read; no DONE is produced after release.

## Timing
- Read latency:
  - Accept at edge N; `bus_done`=1 with valid `bus_rdata` during cycle N+1+`WAIT_STATES`.
  - With `WAIT_STATES`=0, back-to-back reads sustain one per cycle: DONE for read k coincides with acceptance of read k+1.
- Write latency: 0 wait; data is visible to any read accepted at edge N+1 or later.
- `bus_done` is registered (decoded from state flops); no combinational path from request inputs to outputs.
- RAM read is synchronous, for BRAM inference. One write port and one read port.

## Configuration
- `BUS_RESP_RANGE_CHECK_EN` defined:
  - Out-of-range writes are discarded.
  - Out-of-range reads follow normal FSM timing and return 32'hDEAD_BEEF.
  - Any out-of-range accepted request sets `bus_err`, which is cleared only by `rst`.
- Not defined:
  - No range decode; the index is taken modulo `MEM_SIZE_W` (address wraps).
  - `bus_err` is tied 0.

## Test plan
- `WAIT_STATES`=0: write 32'h1122_3344 mask 4'b1111 to 0x10, then read 0x10 next cycle -> `bus_done`=1 with `bus_rdata`=32'h1122_3344 one cycle after read acceptance.
- Byte/half masks: word 0x20 = 32'hFFFF_FFFF. Write wdata 32'hAB00_0000 mask 4'b1000, then 32'h0000_CDCD mask 4'b0011 -> read 0x20 returns 32'hABFF_CDCD.
- `WAIT_STATES`=3: hold `bus_ren` at 0x40 (preloaded 32'h5A5A_0001) for 5 cycles, with a second held read of 0x44 = 32'h0000_0002.
  - `bus_done` is 0 for 3 cycles, then 1 with 32'h5A5A_0001.
  - The second read is accepted on the DONE edge and returns 32'h0000_0002 four cycles later.
- Reset mid-read: `WAIT_STATES`=2, assert `rst` one cycle after read acceptance -> `bus_done`=1 and `bus_rdata`=0 immediately; no DONE pulse after release.
- Simultaneous `bus_ren`=`bus_wen`=1 at 0x08, wdata 32'h7 -> memory word 2 = 7; state returns to IDLE with no read response.
- With `BUS_RESP_RANGE_CHECK_EN`, `MEM_SIZE_W`=1024:
  - Read 0x1000 -> 32'hDEAD_BEEF and `bus_err`=1 (sticky).
  - Write 0x1000 leaves word 0 unchanged.
  - Without the macro, the same write lands in word 0.
